crc_feeder: RTL and testbench

CRC_FEEDER -- requirements
Module: crc_feeder

---
 rtl/crc_feeder_if.sv | 32 +++
 rtl/crc_feeder.sv | 138 +++++++++++++
 tb/tb_crc_feeder.sv | 289 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/crc_feeder_if.sv
// Signal bundle between the CPU push port, the CRC engine write port and crc_feeder.
// slave = the feeder itself, master = whoever drives the pushes and the engine status.
interface crc_feeder_if #(
    parameter int DEPTH_LOG2 = 2
);
    logic                wr_en;
    logic [1:0]          wr_size;
    logic                wr_reflect;
    logic [31:0]         wr_data;
    logic                flush;
    logic                clr_ovf;
    logic                crc_ready;
    logic                crc_wr;
    logic [1:0]          crc_rs;
    logic [3:0]          crc_wrl;
    logic [31:0]         crc_d;
    logic [DEPTH_LOG2:0] level;
    logic                full;
    logic                empty;
    logic                overflow;
    logic                irq;

    modport slave (
        input  wr_en, wr_size, wr_reflect, wr_data, flush, clr_ovf, crc_ready,
        output crc_wr, crc_rs, crc_wrl, crc_d, level, full, empty, overflow, irq
    );

    modport master (
        output wr_en, wr_size, wr_reflect, wr_data, flush, clr_ovf, crc_ready,
        input  crc_wr, crc_rs, crc_wrl, crc_d, level, full, empty, overflow, irq
    );
endinterface

// File: rtl/crc_feeder.sv
// Small FIFO that feeds queued CPU writes into a CRC engine one at a time, pacing on crc_ready.
// Define CRC_FEEDER_IRQ_EN to build the "FIFO drained" interrupt; otherwise irq is tied to 0.
module crc_feeder #(
    parameter int DEPTH_LOG2 = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    crc_feeder_if.slave bus
);
    localparam int                    DEPTH      = 1 << DEPTH_LOG2;
    localparam int                    LVL_W      = DEPTH_LOG2 + 1;
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE    = DEPTH_LOG2'(1);
    localparam logic [LVL_W-1:0]      LVL_ONE    = LVL_W'(1);
    localparam logic [LVL_W-1:0]      FULL_LEVEL = LVL_W'(DEPTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GUARD = 2'd1,
        BUSY  = 2'd2
    } state_e;

    typedef struct packed {
        logic        reflect;
        logic [1:0]  size;
        logic [31:0] data;
    } entry_t;

    entry_t                mem_q [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]      level_q, level_d;
    state_e                state_q, state_d;
    logic                  overflow_q, overflow_d;
    logic                  full, empty, push, pop, ovf_event;
    entry_t                head;

    assign full      = (level_q == FULL_LEVEL);
    assign empty     = (level_q == '0);
    assign head      = mem_q[rd_ptr_q];
    assign push      = bus.wr_en && !full && !bus.flush;
    assign ovf_event = bus.wr_en && full;
    // The issuing pop ignores flush: a write already on the engine bus is never retracted.
    assign pop       = (state_q == IDLE) && !empty && bus.crc_ready;

    always_comb begin
        // NOTE: every variable gets its hold value first so no path through the block infers a latch.
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        level_d    = level_q;
        state_d    = state_q;
        overflow_d = overflow_q;

        if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
        if (pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
        if (push && !pop)      level_d = level_q + LVL_ONE;
        else if (pop && !push) level_d = level_q - LVL_ONE;

        unique case (state_q)
            IDLE:    if (pop) state_d = GUARD;
            GUARD:   state_d = BUSY;  // engine status is stale right after a write
            BUSY:    if (bus.crc_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (bus.flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
            state_d  = IDLE;
        end

        if (bus.clr_ovf) overflow_d = 1'b0;
        if (ovf_event)   overflow_d = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            state_q    <= IDLE;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            state_q    <= state_d;
            overflow_q <= overflow_d;
        end
    end

    // NOTE: storage has no reset; level/pointers alone decide which entries are valid.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= '{reflect: bus.wr_reflect, size: bus.wr_size, data: bus.wr_data};
    end

    always_comb begin
        bus.crc_wr  = pop;
        bus.crc_rs  = 2'b00;
        bus.crc_wrl = 4'b0000;
        bus.crc_d   = 32'h0;
        if (pop) begin
            bus.crc_rs = head.reflect ? 2'b11 : 2'b10;
            unique case (head.size)
                2'b00:   bus.crc_wrl = 4'b0001;
                2'b01:   bus.crc_wrl = 4'b0011;
                default: bus.crc_wrl = 4'b1111;
            endcase
            bus.crc_d = head.data;
        end
    end

    assign bus.level    = level_q;
    assign bus.full     = full;
    assign bus.empty    = empty;
    assign bus.overflow = overflow_q;

`ifdef CRC_FEEDER_IRQ_EN
    logic irq_q, irq_d;

    // Reaching BUSY implies a pop happened, so BUSY->IDLE with nothing queued means "drained".
    always_comb begin
        irq_d = irq_q;
        if (state_q == BUSY && bus.crc_ready && empty) irq_d = 1'b1;
        if (bus.wr_en || bus.flush)                    irq_d = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) irq_q <= 1'b0;
        else        irq_q <= irq_d;
    end

    assign bus.irq = irq_q;
`else
    assign bus.irq = 1'b0;
`endif
endmodule

// File: tb/tb_crc_feeder.sv
// Self-checking bench for crc_feeder: table of single pushes plus hand-written corner sequences,
// with a scoreboard queue checked against every engine write strobe.
module tb_crc_feeder;
    localparam int DEPTH_LOG2 = 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    crc_feeder_if #(.DEPTH_LOG2(DEPTH_LOG2)) bus ();
    crc_feeder #(.DEPTH_LOG2(DEPTH_LOG2)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    typedef struct packed {
        logic [1:0]  rs;
        logic [3:0]  wrl;
        logic [31:0] d;
    } exp_t;

    typedef struct {
        logic [1:0]  size;
        logic        refl;
        logic [31:0] data;
        logic [1:0]  rs;
        logic [3:0]  wrl;
    } vec_t;

    exp_t sb[$];
    int   wr_cyc_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc = 0;
    int   n_wr = 0;
    int   mark = 0;
    int   busy_len = 0;
    int   busy_cnt = 0;
    bit   hold = 1'b0;
    bit   wr_seen = 1'b0;
    exp_t mon_e;
    vec_t vecs[6];

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, got, want, cyc);
        end
    endtask

    function automatic exp_t model(input logic [1:0] size, input logic refl, input logic [31:0] data);
        exp_t e;
        e.rs  = refl ? 2'b11 : 2'b10;
        e.wrl = (size == 2'b00) ? 4'b0001 : (size == 2'b01) ? 4'b0011 : 4'b1111;
        e.d   = data;
        return e;
    endfunction

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [1:0] size, input logic refl, input logic [31:0] data,
                        input bit expect_wr, input exp_t e);
        bus.wr_en      = 1'b1;
        bus.wr_size    = size;
        bus.wr_reflect = refl;
        bus.wr_data    = data;
        if (expect_wr) sb.push_back(e);
        cycle();
        bus.wr_en = 1'b0;
    endtask

    task automatic push_m(input logic [1:0] size, input logic refl, input logic [31:0] data,
                          input bit expect_wr);
        push(size, refl, data, expect_wr, model(size, refl, data));
    endtask

    always @(posedge clk) cyc++;

    // Monitor: every engine write is popped against the scoreboard; idle cycles must be all-zero.
    always @(negedge clk) begin
        if (rst_n && bus.crc_wr) begin
            n_wr++;
            wr_cyc_q.push_back(cyc);
            wr_seen = 1'b1;
            if (sb.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_wr: crc_d=0x%08h while no write was expected", bus.crc_d);
            end else begin
                mon_e = sb.pop_front();
                check("wr_rs", 64'(bus.crc_rs), 64'(mon_e.rs));
                check("wr_wrl", 64'(bus.crc_wrl), 64'(mon_e.wrl));
                check("wr_d", 64'(bus.crc_d), 64'(mon_e.d));
            end
        end else if (rst_n) begin
            check("idle_zero", 64'({bus.crc_rs, bus.crc_wrl, bus.crc_d}), 64'h0);
        end
    end

    // Engine model: after each write, crc_ready drops for busy_len cycles; hold forces it low.
    initial begin
        bus.crc_ready = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            if (!rst_n)             busy_cnt = 0;
            else if (wr_seen)       busy_cnt = busy_len;
            else if (busy_cnt > 0)  busy_cnt--;
            wr_seen = 1'b0;
            bus.crc_ready = !hold && (busy_cnt == 0);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vecs[0] = '{2'b00, 1'b0, 32'h0000_0031, 2'b10, 4'b0001};
        vecs[1] = '{2'b01, 1'b0, 32'h0000_BEEF, 2'b10, 4'b0011};
        vecs[2] = '{2'b10, 1'b0, 32'hDEAD_BEEF, 2'b10, 4'b1111};
        vecs[3] = '{2'b11, 1'b1, 32'hCAFE_F00D, 2'b11, 4'b1111};
        vecs[4] = '{2'b00, 1'b1, 32'hFFFF_FFA5, 2'b11, 4'b0001};
        vecs[5] = '{2'b01, 1'b1, 32'h0000_8001, 2'b11, 4'b0011};

        bus.wr_en      = 1'b0;
        bus.wr_size    = 2'b00;
        bus.wr_reflect = 1'b0;
        bus.wr_data    = 32'h0;
        bus.flush      = 1'b0;
        bus.clr_ovf    = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_level", 64'(bus.level), 64'd0);
        check("rst_empty", 64'(bus.empty), 64'd1);
        check("rst_full", 64'(bus.full), 64'd0);
        check("rst_overflow", 64'(bus.overflow), 64'd0);
        check("rst_irq", 64'(bus.irq), 64'd0);
        check("rst_crc_wr", 64'(bus.crc_wr), 64'd0);
        cycle();
        rst_n = 1'b1;
        cycle();

        // Single pushes into an idle, empty FIFO: write must follow one cycle later
        for (int i = 0; i < 6; i++) begin
            push(vecs[i].size, vecs[i].refl, vecs[i].data, 1'b1,
                 '{rs: vecs[i].rs, wrl: vecs[i].wrl, d: vecs[i].data});
            @(negedge clk);
            check($sformatf("tbl%0d_latency_wr", i), 64'(bus.crc_wr), 64'd1);
            check($sformatf("tbl%0d_level_during", i), 64'(bus.level), 64'd1);
            cycle();
            @(negedge clk);
            check($sformatf("tbl%0d_level_after", i), 64'(bus.level), 64'd0);
            check($sformatf("tbl%0d_empty_after", i), 64'(bus.empty), 64'd1);
            repeat (3) cycle();
        end

        // Long engine busy time: second write waits for GUARD + busy + return to IDLE
        busy_len = 32;
        wr_cyc_q.delete();
        push_m(2'b10, 1'b1, 32'h1234_5678, 1'b1);
        push_m(2'b00, 1'b0, 32'h0000_005A, 1'b1);
        @(negedge clk);
        check("push_pop_same_cycle_level", 64'(bus.level), 64'd1);
        for (int i = 0; i < 100 && wr_cyc_q.size() < 2; i++) cycle();
        check("busy_write_count", 64'(wr_cyc_q.size()), 64'd2);
        if (wr_cyc_q.size() == 2)
            check("busy_write_gap", 64'(wr_cyc_q[1] - wr_cyc_q[0]), 64'd34);
        busy_len = 0;
        repeat (40) cycle();

        // Fill to full with the engine stalled, then overflow and clear it
        hold = 1'b1;
        cycle();
        for (int i = 0; i < 4; i++) push_m(2'b00, 1'b0, 32'hA0 + 32'(i), 1'b0);
        @(negedge clk);
        check("fill_full", 64'(bus.full), 64'd1);
        check("fill_level", 64'(bus.level), 64'd4);
        check("fill_no_overflow", 64'(bus.overflow), 64'd0);
        push_m(2'b00, 1'b0, 32'hA4, 1'b0);
        @(negedge clk);
        check("ovf_set", 64'(bus.overflow), 64'd1);
        check("ovf_level", 64'(bus.level), 64'd4);
        bus.wr_en   = 1'b1;
        bus.clr_ovf = 1'b1;
        cycle();
        bus.wr_en   = 1'b0;
        bus.clr_ovf = 1'b0;
        @(negedge clk);
        check("ovf_event_beats_clear", 64'(bus.overflow), 64'd1);
        bus.clr_ovf = 1'b1;
        cycle();
        bus.clr_ovf = 1'b0;
        @(negedge clk);
        check("ovf_cleared", 64'(bus.overflow), 64'd0);
        bus.flush = 1'b1;
        cycle();
        bus.flush = 1'b0;
        @(negedge clk);
        check("flush_level", 64'(bus.level), 64'd0);
        check("flush_empty", 64'(bus.empty), 64'd1);
        bus.flush = 1'b1;
        bus.wr_en = 1'b1;
        cycle();
        bus.flush = 1'b0;
        bus.wr_en = 1'b0;
        @(negedge clk);
        check("push_with_flush_dropped", 64'(bus.level), 64'd0);
        hold = 1'b0;
        repeat (4) cycle();

        // Flush while BUSY with two entries queued: nothing more may reach the engine
        busy_len = 20;
        push_m(2'b00, 1'b0, 32'h0000_0011, 1'b1);
        push_m(2'b01, 1'b0, 32'h0000_2222, 1'b0);
        push_m(2'b10, 1'b1, 32'h3333_3333, 1'b0);
        repeat (3) cycle();
        @(negedge clk);
        check("busy_queued_level", 64'(bus.level), 64'd2);
        cycle();
        bus.flush = 1'b1;
        cycle();
        bus.flush = 1'b0;
        @(negedge clk);
        check("busy_flush_level", 64'(bus.level), 64'd0);
        check("busy_flush_empty", 64'(bus.empty), 64'd1);
        mark = n_wr;
        repeat (30) cycle();
        check("busy_flush_no_write", 64'(n_wr - mark), 64'd0);

        // Three mixed-size entries drain in order; drained interrupt when built in
        busy_len = 3;
        mark = n_wr;
        push_m(2'b00, 1'b0, 32'h0000_00C1, 1'b1);
        push_m(2'b01, 1'b0, 32'h0000_C2C2, 1'b1);
        push_m(2'b10, 1'b0, 32'hC3C3_C3C3, 1'b1);
        for (int i = 0; i < 60 && (n_wr - mark) < 3; i++) cycle();
        check("drain_write_count", 64'(n_wr - mark), 64'd3);
        repeat (8) cycle();
        @(negedge clk);
`ifdef CRC_FEEDER_IRQ_EN
        check("drain_irq_set", 64'(bus.irq), 64'd1);
`else
        check("drain_irq_absent", 64'(bus.irq), 64'd0);
`endif
        cycle();
        push_m(2'b00, 1'b0, 32'h0000_0044, 1'b1);
        @(negedge clk);
        check("irq_cleared_by_push", 64'(bus.irq), 64'd0);
        repeat (8) cycle();

        // Asynchronous reset in the middle of BUSY with two entries queued
        busy_len = 30;
        push_m(2'b10, 1'b0, 32'h5555_0001, 1'b1);
        push_m(2'b00, 1'b0, 32'h5555_0002, 1'b0);
        push_m(2'b01, 1'b0, 32'h5555_0003, 1'b0);
        repeat (2) cycle();
        @(negedge clk);
        check("pre_reset_level", 64'(bus.level), 64'd2);
        cycle();
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_level", 64'(bus.level), 64'd0);
        check("async_rst_empty", 64'(bus.empty), 64'd1);
        check("async_rst_full", 64'(bus.full), 64'd0);
        check("async_rst_outputs", 64'({bus.crc_wr, bus.crc_rs, bus.crc_wrl, bus.crc_d}), 64'h0);
        check("async_rst_overflow", 64'(bus.overflow), 64'd0);
        check("async_rst_irq", 64'(bus.irq), 64'd0);
        check("async_rst_sb_drained", 64'(sb.size()), 64'd0);
        sb.delete();
        repeat (2) cycle();
        rst_n = 1'b1;
        busy_len = 0;
        cycle();
        push_m(2'b00, 1'b1, 32'h0000_0077, 1'b1);
        @(negedge clk);
        check("post_reset_latency_wr", 64'(bus.crc_wr), 64'd1);
        repeat (5) cycle();

        check("scoreboard_empty", 64'(sb.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
